inst_issue_queue: RTL and testbench

//  Parametrised instruction buffer between IF and ID. Accepts up to LANES fetched instructions
//  per cycle and presents the oldest LANES entries to the decoder. The decoder reports how many
//  it consumed (0..LANES), so partial issue works for any width. Flushes are synchronous.

---
 rtl/inst_issue_queue_pkg.sv | 28 ++
 rtl/inst_issue_queue_if.sv | 25 ++
 rtl/inst_issue_queue_ram.sv | 34 +++
 rtl/inst_issue_queue.sv | 91 +++++++++
 tb/tb_inst_issue_queue.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/inst_issue_queue_pkg.sv
// Shared IF->ID bus-width macros and helpers for the instruction issue queue.
// IF and ID stages size their buses from the two macros below.
`ifndef INST_ISSUE_QUEUE_BUS_WIDTHS
`define INST_ISSUE_QUEUE_BUS_WIDTHS
`define LaneIfToIdBusLen(data_w) (data_w)
`define IfToIdBusLen(lanes, data_w) ((lanes) * (data_w))
`endif

package inst_issue_queue_pkg;

    localparam int MAX_LANES = 4;

    typedef logic [$clog2(MAX_LANES + 1)-1:0] lane_cnt_t;

    // Counts contiguous valid lanes from lane 0; the first gap ends the group.
    function automatic lane_cnt_t lead_ones(input logic [MAX_LANES-1:0] valid);
        lane_cnt_t n;
        logic      run;
        n   = '0;
        run = 1'b1;
        for (int k = 0; k < MAX_LANES; k++) begin
            run = run & valid[k];
            n   = n + lane_cnt_t'(run);
        end
        return n;
    endfunction

endpackage

// File: rtl/inst_issue_queue_if.sv
// IF->queue->ID handshake bundle; slave is the queue, master is the IF/ID side.
interface inst_issue_queue_if #(
    parameter int DATA_W = 64,
    parameter int LANES  = 2,
    parameter int DEPTH  = 8
);
    logic                                     flush_i;
    logic [LANES-1:0]                         in_valid_i;
    logic [`IfToIdBusLen(LANES, DATA_W)-1:0]  in_data_i;
    logic                                     in_ready_o;
    logic [LANES-1:0]                         out_valid_o;
    logic [`IfToIdBusLen(LANES, DATA_W)-1:0]  out_data_o;
    logic [$clog2(LANES + 1)-1:0]             out_take_i;
    logic [$clog2(DEPTH + 1)-1:0]             count_o;

    modport master (
        output flush_i, in_valid_i, in_data_i, out_take_i,
        input  in_ready_o, out_valid_o, out_data_o, count_o
    );

    modport slave (
        input  flush_i, in_valid_i, in_data_i, out_take_i,
        output in_ready_o, out_valid_o, out_data_o, count_o
    );
endinterface

// File: rtl/inst_issue_queue_ram.sv
// Ring storage for the issue queue: LANES write ports and LANES combinational
// read ports, each addressed as base pointer plus lane offset (mod DEPTH).
module iq_ring_ram #(
    parameter  int DATA_W = 64,
    parameter  int LANES  = 2,
    parameter  int DEPTH  = 8,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic                                    clk,
    input  logic [LANES-1:0]                        wr_en_i,
    input  logic [PTR_W-1:0]                        wr_base_i,
    input  logic [`IfToIdBusLen(LANES, DATA_W)-1:0] wr_data_i,
    input  logic [PTR_W-1:0]                        rd_base_i,
    output logic [`IfToIdBusLen(LANES, DATA_W)-1:0] rd_data_o
);
    logic [`LaneIfToIdBusLen(DATA_W)-1:0] mem_q [DEPTH];

    // NOTE: the storage array has no reset; validity is tracked by the occupancy count,
    // so stale contents are never observed and the array can map onto plain flops/RAM.
    always_ff @(posedge clk) begin
        for (int j = 0; j < LANES; j++) begin
            if (wr_en_i[j]) begin
                mem_q[wr_base_i + PTR_W'(j)] <= wr_data_i[j*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < LANES; k++) begin
            rd_data_o[k*DATA_W +: DATA_W] = mem_q[rd_base_i + PTR_W'(k)];
        end
    end
endmodule

// File: rtl/inst_issue_queue.sv
// Multi-lane instruction buffer between IF and ID: accepts up to LANES entries per
// cycle, presents the oldest LANES to ID, and retires however many ID takes.
module inst_issue_queue
    import inst_issue_queue_pkg::*;
#(
    parameter  int DATA_W = 64,
    parameter  int LANES  = 2,
    parameter  int DEPTH  = 8,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    inst_issue_queue_if.slave bus
);
    localparam int               CNT_W     = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] LANES_C   = CNT_W'(LANES);
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - LANES);

    logic [PTR_W-1:0]                        head_q, head_d;
    logic [PTR_W-1:0]                        tail_q, tail_d;
    logic [CNT_W-1:0]                        count_q, count_d;
    logic                                    in_ready;
    logic [CNT_W-1:0]                        n_in, n_take, take_req, avail;
    logic [LANES-1:0]                        wr_en;
    logic [`IfToIdBusLen(LANES, DATA_W)-1:0] rd_data;

    // Ready looks only at registered occupancy, so ID's take never reaches IF combinationally.
    assign in_ready = (count_q <= READY_MAX);
    assign avail    = (count_q < LANES_C) ? count_q : LANES_C;
    assign take_req = CNT_W'(bus.out_take_i);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        n_in   = '0;
        wr_en  = '0;
        n_take = (take_req < avail) ? take_req : avail;
        if (in_ready) begin
            n_in = CNT_W'(lead_ones(MAX_LANES'(bus.in_valid_i)));
        end
        for (int j = 0; j < LANES; j++) begin
            wr_en[j] = rst_n && !bus.flush_i && (CNT_W'(j) < n_in);
        end
        head_d  = head_q + PTR_W'(n_take);
        tail_d  = tail_q + PTR_W'(n_in);
        count_d = count_q + n_in - n_take;
    end

    // NOTE: registers use non-blocking assignments so each one samples pre-edge values
    // regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    iq_ring_ram #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_base_i (tail_q),
        .wr_data_i (bus.in_data_i),
        .rd_base_i (head_q),
        .rd_data_o (rd_data)
    );

    // Lanes past the occupancy are forced to zero so ID never sees stale storage.
    always_comb begin
        bus.out_valid_o = '0;
        bus.out_data_o  = '0;
        for (int k = 0; k < LANES; k++) begin
            if (count_q > CNT_W'(k)) begin
                bus.out_valid_o[k]                = 1'b1;
                bus.out_data_o[k*DATA_W +: DATA_W] = rd_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.in_ready_o = in_ready;
    assign bus.count_o    = count_q;

    take_within_valid: assert property (@(posedge clk) disable iff (!rst_n) take_req <= avail);
endmodule

// File: tb/tb_inst_issue_queue.sv
// Bench for inst_issue_queue: directed scenarios on an 8x2 queue, random traffic on
// both an 8x2 and a 16x4 queue, every cycle compared against a queue-based model.
module tb_inst_issue_queue;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   chk_en   = 1'b0;

    always #5 clk = ~clk;

    inst_issue_queue_if #(.DATA_W(DW), .LANES(2), .DEPTH(8))  ifa ();
    inst_issue_queue_if #(.DATA_W(DW), .LANES(4), .DEPTH(16)) ifb ();

    inst_issue_queue #(.DATA_W(DW), .LANES(2), .DEPTH(8))  dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    inst_issue_queue #(.DATA_W(DW), .LANES(4), .DEPTH(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    logic [DW-1:0] drained_b[$];

    function automatic int lead(input logic [3:0] v);
        int n = 0;
        for (int k = 0; k < 4; k++) begin
            if (!v[k]) break;
            n++;
        end
        return n;
    endfunction

    function automatic int min3(input int a, input int b, input int c);
        int m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        return m;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [1:0] v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                           input logic [1:0] take, input logic fl);
        ifa.in_valid_i = v;
        ifa.in_data_i  = {d1, d0};
        ifa.out_take_i = take;
        ifa.flush_i    = fl;
    endtask

    // Reference model: a plain FIFO of words, updated with the inputs seen at each edge.
    always @(posedge clk) begin : model_a
        int ni, nt;
        if (!rst_n || ifa.flush_i) begin
            qa.delete();
        end else begin
            ni = ((8 - qa.size()) >= 2) ? lead(4'(ifa.in_valid_i)) : 0;
            nt = min3(int'(ifa.out_take_i), qa.size(), 2);
            repeat (nt) void'(qa.pop_front());
            for (int j = 0; j < ni; j++) qa.push_back(ifa.in_data_i[j*DW +: DW]);
        end
    end

    always @(posedge clk) begin : model_b
        int ni, nt;
        if (!rst_n || ifb.flush_i) begin
            qb.delete();
        end else begin
            ni = ((16 - qb.size()) >= 4) ? lead(ifb.in_valid_i) : 0;
            nt = min3(int'(ifb.out_take_i), qb.size(), 4);
            repeat (nt) drained_b.push_back(qb.pop_front());
            for (int j = 0; j < ni; j++) qb.push_back(ifb.in_data_i[j*DW +: DW]);
        end
    end

    always @(negedge clk) begin : compare
        logic [3:0]      ev;
        logic [4*DW-1:0] ed;
        if (chk_en) begin
            ev = '0;
            ed = '0;
            for (int k = 0; k < 2; k++) begin
                if (k < qa.size()) begin
                    ev[k]          = 1'b1;
                    ed[k*DW +: DW] = qa[k];
                end
            end
            check("a_valid", ifa.out_valid_o, ev);
            check("a_data", ifa.out_data_o, ed);
            check("a_count", ifa.count_o, qa.size());
            check("a_ready", ifa.in_ready_o, (8 - qa.size()) >= 2);

            ev = '0;
            ed = '0;
            for (int k = 0; k < 4; k++) begin
                if (k < qb.size()) begin
                    ev[k]          = 1'b1;
                    ed[k*DW +: DW] = qb[k];
                end
            end
            check("b_valid", ifb.out_valid_o, ev);
            check("b_data", ifb.out_data_o, ed);
            check("b_count", ifb.count_o, qb.size());
            check("b_ready", ifb.in_ready_o, (16 - qb.size()) >= 4);
            check("b_count_bound", ifb.count_o <= 16, 1'b1);
        end
    end

    initial begin
        logic [DW-1:0] w [8];
        logic [3:0]    v;
        int            nxt, cyc, n, lim;

        w = '{32'hA0, 32'hA1, 32'hB0, 32'hB1, 32'hC0, 32'hC1, 32'hD0, 32'hD1};

        // Reset held two cycles with lanes offered.
        rst_n = 1'b0;
        drive_a(2'b11, 32'h11, 32'h22, 2'd0, 1'b0);
        ifb.in_valid_i = '0;
        ifb.in_data_i  = '0;
        ifb.out_take_i = '0;
        ifb.flush_i    = 1'b0;
        tick();
        tick();
        check("t1_valid", ifa.out_valid_o, 2'b00);
        check("t1_count", ifa.count_o, 0);
        check("t1_ready", ifa.in_ready_o, 1'b1);
        check("t1_data", ifa.out_data_o, 0);
        rst_n = 1'b1;
        drive_a(2'b00, '0, '0, 2'd0, 1'b0);
        chk_en = 1'b1;

        // Fill to full with two-lane writes.
        for (int i = 0; i < 4; i++) begin
            drive_a(2'b11, w[2*i], w[2*i+1], 2'd0, 1'b0);
            tick();
            check("t2_count", ifa.count_o, 2 * (i + 1));
        end
        drive_a(2'b00, '0, '0, 2'd0, 1'b0);
        check("t2_ready_full", ifa.in_ready_o, 1'b0);
        check("t2_lane0", ifa.out_data_o[DW-1:0], w[0]);
        check("t2_lane1", ifa.out_data_o[2*DW-1:DW], w[1]);

        // Drain one per cycle; ready returns once occupancy reaches 6.
        for (int i = 0; i < 8; i++) begin
            drive_a(2'b00, '0, '0, 2'd1, 1'b0);
            tick();
            check("t3_count", ifa.count_o, 7 - i);
            check("t3_ready", ifa.in_ready_o, i >= 1);
            if (i < 7) check("t3_lane0", ifa.out_data_o[DW-1:0], w[i+1]);
        end
        drive_a(2'b00, '0, '0, 2'd0, 1'b0);
        check("t3_empty", ifa.out_valid_o, 2'b00);

        // Build occupancy 7, then offer one lane while not ready.
        for (int i = 0; i < 3; i++) begin
            drive_a(2'b11, 32'h100 + 32'(2 * i), 32'h101 + 32'(2 * i), 2'd0, 1'b0);
            tick();
        end
        drive_a(2'b01, 32'h106, 32'hDEAD, 2'd0, 1'b0);
        tick();
        check("t4_count7", ifa.count_o, 7);
        check("t4_not_ready", ifa.in_ready_o, 1'b0);
        drive_a(2'b01, 32'hBAD0, 32'hBAD1, 2'd2, 1'b0);
        tick();
        check("t4_no_write", ifa.count_o, 5);
        check("t4_lane0", ifa.out_data_o[DW-1:0], 32'h102);
        check("t4_lane1", ifa.out_data_o[2*DW-1:DW], 32'h103);
        drive_a(2'b10, 32'hBAD2, 32'hBAD3, 2'd0, 1'b0);
        tick();
        check("t4_gap_lane", ifa.count_o, 5);

        // Flush wins over simultaneous enqueue and take.
        drive_a(2'b11, 32'hF0, 32'hF1, 2'd2, 1'b1);
        tick();
        check("t6_count", ifa.count_o, 0);
        check("t6_valid", ifa.out_valid_o, 2'b00);
        check("t6_ready", ifa.in_ready_o, 1'b1);
        drive_a(2'b01, 32'h77, 32'hBAD, 2'd0, 1'b0);
        tick();
        check("t6_lane0", ifa.out_data_o[DW-1:0], 32'h77);
        check("t6_valid_after", ifa.out_valid_o, 2'b01);

        // Random traffic with occasional flushes on the narrow queue.
        for (int i = 0; i < 300; i++) begin
            lim = (qa.size() < 2) ? qa.size() : 2;
            drive_a(2'($urandom), $urandom, $urandom, 2'($urandom_range(lim, 0)),
                    $urandom_range(19, 0) == 0);
            tick();
        end
        drive_a(2'b00, '0, '0, 2'd0, 1'b0);

        // Stream 40 incrementing words through the wide queue across pointer wrap.
        nxt = 0;
        cyc = 0;
        while ((nxt < 40 || qb.size() != 0) && cyc < 3000) begin
            v = 4'($urandom);
            n = lead(v);
            if (n > 40 - nxt) begin
                n = 40 - nxt;
                v = 4'((1 << n) - 1);
            end
            for (int j = 0; j < 4; j++) begin
                ifb.in_data_i[j*DW +: DW] = (j < n) ? DW'(nxt + j) : $urandom;
            end
            ifb.in_valid_i = v;
            lim = (qb.size() < 4) ? qb.size() : 4;
            ifb.out_take_i = 3'($urandom_range(lim, 0));
            if ((16 - qb.size()) >= 4) nxt += n;
            tick();
            cyc++;
        end
        ifb.in_valid_i = '0;
        ifb.out_take_i = '0;
        tick();
        check("b_stream_finished", cyc < 3000, 1'b1);
        check("b_drained_count", drained_b.size(), 40);
        for (int i = 0; i < 40; i++) begin
            check("b_order", (i < drained_b.size()) ? drained_b[i] : 'x, i);
        end
        check("b_final_count", ifb.count_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
